// File: rtl/sampler_pkg.sv
// Shared widths and depths for the base-sampler randomness path.
// IN_W       : PRNG beat width
// RDM_W      : word width served to the base sampler
// ACC_W      : gearbox accumulator width (must exceed RDM_W-1 + IN_W)
// FIFO_DEPTH : buffered RDM_W words
// CNT_W      : width of the accumulator bit count (0..ACC_W-1)
// LVL_W      : width of the FIFO occupancy (0..FIFO_DEPTH)
package sampler_pkg;

  localparam int unsigned IN_W       = 64;
  localparam int unsigned RDM_W      = 144;
  localparam int unsigned ACC_W      = 208;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/rdm_fifo.sv
// Small circular buffer of random words between the gearbox and the consumer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointers and level only)
//   push      : write push_data at the tail (caller guarantees not full)
//   push_data : word to store
//   pop       : drop the head entry (caller guarantees not empty)
//   level     : number of stored entries
//   head      : oldest stored entry
module rdm_fifo #(
  parameter int unsigned Width = 144,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned LvlW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [Width-1:0] push_data,
  input  logic            pop,
  output logic [LvlW-1:0] level,
  output logic [Width-1:0] head
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [LvlW-1:0]  level_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; the level gates what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rdm_gearbox.sv
// Repacks 64-bit PRNG beats into 144-bit words for the base sampler, MSB first,
// with a two-entry word buffer and a registered output word.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_data   : PRNG beat, in_valid qualifies it, in_ready accepts it
//   rdm_req   : one-cycle request; rdm144 is loaded at the end of that cycle
//   rdm144    : served word, held until the next successful request
//   rdm_avail : at least one word buffered
//   level     : buffered words (0..2)
//   underflow : sticky, a request found the buffer empty
module rdm_gearbox
  import sampler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rdm_req,
  output logic [RDM_W-1:0] rdm144,
  output logic             rdm_avail,
  output logic [LVL_W-1:0] level,
  output logic             underflow
);

  // Oldest bit sits at acc_q[ACC_W-1]; valid bits are the top acc_cnt_q bits.
  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, cnt_base;
  logic             extract, accept, pop;
  logic [RDM_W-1:0] fifo_head;

  assign extract   = !rst && (acc_cnt_q >= CNT_W'(RDM_W)) && (level < LVL_W'(FIFO_DEPTH));
  assign in_ready  = !rst && ((acc_cnt_q <= CNT_W'(RDM_W - 1)) || extract);
  assign accept    = in_valid && in_ready;
  // No bypass: a word extracted this cycle is not poppable until the next.
  assign pop       = !rst && rdm_req && (level != '0);
  assign rdm_avail = (level != '0);

  always_comb begin
    acc_base = acc_q;
    cnt_base = acc_cnt_q;
    if (extract) begin
      acc_base = acc_q << RDM_W;
      cnt_base = acc_cnt_q - CNT_W'(RDM_W);
    end
    acc_d     = acc_base;
    acc_cnt_d = cnt_base;
    if (accept) begin
      // Land the new beat directly below the bits still held.
      acc_d     = acc_base | ({in_data, {(ACC_W - IN_W){1'b0}}} >> cnt_base);
      acc_cnt_d = cnt_base + CNT_W'(IN_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
      rdm144    <= '0;
      underflow <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      if (pop) rdm144 <= fifo_head;
      if (rdm_req && (level == '0)) underflow <= 1'b1;
    end
  end

  rdm_fifo #(
    .Width (RDM_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (extract),
    .push_data (acc_q[ACC_W-1 -: RDM_W]),
    .pop       (pop),
    .level     (level),
    .head      (fifo_head)
  );

endmodule
